// File: rtl/systolic_tile_ctrl_pkg.sv
// Shared definitions for the systolic tile controller: FSM state encoding and
// helpers that size the beat/word/wait counter from the array geometry.
package systolic_tile_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_LAUNCH = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  function automatic int n_in(input int rows, input int cols, input int k);
    return rows * k + k * cols;
  endfunction

  function automatic int n_out(input int rows, input int cols);
    return rows * cols;
  endfunction

  // One counter serves beat index, wait cycles and drain index, so it must cover all three.
  function automatic int ctr_width(input int n_i, input int n_o, input int timeout);
    int m;
    m = n_i;
    if (n_o > m) m = n_o;
    if (timeout + 1 > m) m = timeout + 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/systolic_tile_ctrl.sv
// Host-side initiator for the systolic MAC array: gathers an A/B operand tile from
// a byte stream, launches the array, captures C and streams it back word by word.
module systolic_tile_ctrl
  import systolic_tile_ctrl_pkg::*;
#(
  parameter int DW      = 8,
  parameter int ACCW    = 32,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int K       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW-1:0]             in_data,
  output logic                      arr_start,
  output logic [ROWS*K*DW-1:0]      arr_A,
  output logic [K*COLS*DW-1:0]      arr_B,
  input  logic                      arr_done,
  input  logic [ROWS*COLS*ACCW-1:0] arr_C,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACCW-1:0]           out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      err
);

  localparam int N_IN  = n_in(ROWS, COLS, K);
  localparam int N_OUT = n_out(ROWS, COLS);
  localparam int N_A   = ROWS * K;
  localparam int N_B   = K * COLS;
  localparam int CW    = ctr_width(N_IN, N_OUT, TIMEOUT);
  localparam int IW    = $clog2(N_IN);
  localparam int OW    = $clog2(N_OUT);

  localparam logic [CW-1:0] LAST_IN  = CW'(N_IN - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(N_OUT - 1);
  localparam logic [CW-1:0] LAST_WT  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [2:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_err;
  logic [DW-1:0]   r_ops [N_IN];
  logic [ACCW-1:0] r_c   [N_OUT];

  logic w_in_fire;
  logic w_drain;
  logic w_capture;

  assign w_in_fire = in_valid & r_in_ready;
  assign w_drain   = (r_state == ST_DRAIN);
  assign w_capture = (r_state == ST_WAIT) & arr_done;

  assign in_ready  = r_in_ready;
  assign arr_start = (r_state == ST_LAUNCH);
  assign busy      = (r_state != ST_IDLE);
  assign err       = r_err;
  assign out_valid = w_drain;
  assign out_data  = w_drain ? r_c[r_cnt[OW-1:0]] : '0;
  assign out_last  = w_drain && (r_cnt == LAST_OUT);

  // Beat index doubles as storage address; A and B share one flat operand store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) r_ops[i] <= '0;
    end else if (w_in_fire) begin
      r_ops[r_cnt[IW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) r_c[i] <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < N_OUT; i++) r_c[i] <= arr_C[i*ACCW +: ACCW];
    end
  end

  generate
    for (genvar gi = 0; gi < N_A; gi++) begin : g_pack_a
      assign arr_A[gi*DW +: DW] = r_ops[gi];
    end
    for (genvar gi = 0; gi < N_B; gi++) begin : g_pack_b
      assign arr_B[gi*DW +: DW] = r_ops[N_A + gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_cnt   <= ONE;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_in_fire) begin
            if (r_cnt == LAST_IN) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= ST_LAUNCH;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
        end
        ST_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (arr_done) begin
            r_cnt   <= '0;
            r_state <= ST_DRAIN;
          end else if (r_cnt == LAST_WT) begin
            r_err      <= 1'b1;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (r_cnt == LAST_OUT) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Directed bench for systolic_tile_ctrl: table of operand tiles with expected C words,
// plus hand sequences for timeout, stray done and reset during drain.
module tb_systolic_tile_ctrl;

  localparam int DW      = 8;
  localparam int ACCW    = 32;
  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int K       = 4;
  localparam int TIMEOUT = 64;
  localparam int NI      = 32;
  localparam int NO      = 16;

  typedef struct {
    logic [15:0][7:0]  a;
    logic [15:0][7:0]  b;
    logic [15:0][31:0] exp_c;
    bit                bp;
    int                stall_at;
  } vec_t;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [DW-1:0]             in_data = '0;
  logic                      arr_start;
  logic [ROWS*K*DW-1:0]      arr_A;
  logic [K*COLS*DW-1:0]      arr_B;
  logic                      arr_done = 1'b0;
  logic [ROWS*COLS*ACCW-1:0] arr_C = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [ACCW-1:0]           out_data;
  logic                      out_last;
  logic                      busy;
  logic                      err;

  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  bit   model_en = 1'b1;
  bit   idle_req = 1'b0;
  bit   out_seen = 1'b0;
  vec_t vecs [4];

  systolic_tile_ctrl #(
    .DW(DW), .ACCW(ACCW), .ROWS(ROWS), .COLS(COLS), .K(K), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .arr_start(arr_start), .arr_A(arr_A), .arr_B(arr_B),
    .arr_done(arr_done), .arr_C(arr_C),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (arr_start) start_cnt++;
    if (out_valid) out_seen = 1'b1;
  end

  function automatic logic [NO*ACCW-1:0] matmul(input logic [127:0] a, input logic [127:0] b);
    logic [NO*ACCW-1:0] res;
    int s;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += int'($signed(a[(r*4+k)*8 +: 8])) * int'($signed(b[(k*4+c)*8 +: 8]));
        res[(r*4+c)*32 +: 32] = s;
      end
    return res;
  endfunction

  // Behavioural array: a few cycles after start, returns A*B with a done pulse.
  initial begin
    logic [NO*ACCW-1:0] c;
    forever begin
      @(posedge clk); #1;
      if (arr_start && model_en) begin
        c = matmul(arr_A, arr_B);
        repeat (5) @(posedge clk);
        #1 arr_C = c; arr_done = 1'b1;
        @(posedge clk);
        #1 arr_done = 1'b0;
      end else if (idle_req) begin
        arr_C = {16{32'h5A5A_0001}}; arr_done = 1'b1;
        @(posedge clk);
        #1 arr_done = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic load_tile(input int v);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    check("in_ready_idle", in_ready, 1);
    for (int i = 0; i < NI; i++) begin
      if (vecs[v].bp)
        while ($urandom_range(0, 1) == 0) begin in_valid = 1'b0; @(negedge clk); end
      in_valid = 1'b1;
      in_data  = (i < 16) ? vecs[v].a[i] : vecs[v].b[i-16];
      guard = 0;
      while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
      if (guard >= 50) check("in_ready_timeout", 0, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("start_latency", arr_start, 1);
    check("in_ready_after_last", in_ready, 0);
    check("arr_A", arr_A, vecs[v].a);
    check("arr_B", arr_B, vecs[v].b);
    $display("tile %0d loaded, arr_start=%0b", v, arr_start);
  endtask

  task automatic drain_tile(input int v, input int base, input int abort_at);
    int guard;
    out_ready = 1'b1;
    guard = 0;
    while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
    check("out_valid_arrives", out_valid, 1);
    check("start_pulses", start_cnt - base, 1);
    for (int w = 0; w < NO; w++) begin
      if (w == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy_err_start", {busy, err, arr_start, in_ready, out_last}, 0);
        check("rst_arr_AB", {arr_A, arr_B}, 0);
        $display("reset applied during drain at word %0d", w);
        rst_n = 1'b1;
        out_ready = 1'b0;
        return;
      end
      check("out_valid", out_valid, 1);
      check("out_data", out_data, vecs[v].exp_c[w]);
      check("out_last", out_last, (w == NO - 1));
      $display("tile %0d word %0d data=%0h last=%0b", v, w, out_data, out_last);
      if (w == vecs[v].stall_at) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_data", out_data, vecs[v].exp_c[w]);
          check("stall_valid_last", {out_valid, out_last}, {1'b1, 1'b0});
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("drain_done_valid", out_valid, 0);
    check("drain_done_busy", busy, 0);
  endtask

  initial begin
    int n;
    int base;
    for (int i = 0; i < 16; i++) begin
      vecs[0].a[i] = ((i / 4) == (i % 4)) ? 8'd1 : 8'd0;
      vecs[0].b[i] = 8'(i);
      vecs[0].exp_c[i] = 32'(i);
      vecs[1].a[i] = 8'hFF;
      vecs[1].b[i] = 8'd127;
      vecs[1].exp_c[i] = 32'hFFFF_FE04;
      vecs[2].a[i] = 8'(i * 7 - 50);
      vecs[2].b[i] = 8'(i * 13 + 3);
      vecs[3].a[i] = vecs[0].a[i];
      vecs[3].b[i] = 8'(100 + i);
      vecs[3].exp_c[i] = 32'(100 + i);
    end
    vecs[2].exp_c = matmul(vecs[2].a, vecs[2].b);
    vecs[0].bp = 0; vecs[0].stall_at = -1;
    vecs[1].bp = 0; vecs[1].stall_at = -1;
    vecs[2].bp = 1; vecs[2].stall_at = -1;
    vecs[3].bp = 0; vecs[3].stall_at = 7;

    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_flags", {busy, err, arr_start, out_valid, out_last}, 0);
    check("reset_out_data", out_data, 0);
    check("reset_arr_AB", {arr_A, arr_B}, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      base = start_cnt;
      load_tile(v);
      drain_tile(v, base, -1);
    end

    // Stray done while idle must not start a drain.
    idle_req = 1'b1;
    @(negedge clk);
    idle_req = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done_ignored", {busy, out_valid}, 0);
    $display("stray arr_done in idle: busy=%0b out_valid=%0b", busy, out_valid);

    model_en = 1'b0;
    out_seen = 1'b0;
    load_tile(1);
    n = 0;
    while (!err && n < 200) begin @(negedge clk); n++; end
    check("timeout_cycles", n, TIMEOUT + 1);
    check("timeout_idle", busy, 0);
    check("timeout_no_output", out_seen, 0);
    $display("timeout: err after %0d cycles from arr_start", n);
    model_en = 1'b1;

    base = start_cnt;
    load_tile(2);
    drain_tile(2, base, 5);
    check("err_cleared", err, 0);
    base = start_cnt;
    load_tile(3);
    drain_tile(3, base, -1);
    check("err_after_recover", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
